// File: rtl/if_pc_gen_pkg.sv
// Shared project types for the instruction-fetch PC generator: reset
// polarity, instruction address type, fetch FSM states and default constants.
package if_pc_gen_pkg;

    // Reset is a single active-high line; RST_ENABLE names the asserted level.
    typedef logic reset_status_t;
    localparam reset_status_t RST_ENABLE = 1'b1;

    // Byte address of an instruction word (pc, flush_pc, branch_target).
    typedef logic [31:0] inst_addr_t;

    localparam inst_addr_t RESET_VECTOR_DEF = 32'hBFC0_0000;
    localparam inst_addr_t PC_INC_DEF       = 32'd4;

    // S_IDLE only exists for the first cycle after reset, with the ROM disabled.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_pc_gen_if.sv
// Bundle of the PC generator's control inputs and fetch outputs.
// master: the pipeline controller / ROM side; slave: the PC generator.
interface if_pc_gen_if;
    import if_pc_gen_pkg::*;

    logic [5:0] stall;
    logic       flush;
    inst_addr_t flush_pc;
    logic       branch_flag;
    inst_addr_t branch_target;
    logic       rom_rdy;
    logic       rom_ce;
    inst_addr_t rom_addr;
    inst_addr_t pc;
    logic       stallreq_if;

    modport master (
        output stall, flush, flush_pc, branch_flag, branch_target, rom_rdy,
        input  rom_ce, rom_addr, pc, stallreq_if
    );

    modport slave (
        input  stall, flush, flush_pc, branch_flag, branch_target, rom_rdy,
        output rom_ce, rom_addr, pc, stallreq_if
    );

endinterface

// File: rtl/pc_redirect_buf.sv
// One-entry buffer that remembers a branch resolved while fetch was held,
// so the redirect is applied on the first cycle the PC may advance again.
module pc_redirect_buf
    import if_pc_gen_pkg::*;
(
    input  logic          clk,
    input  reset_status_t rst,
    input  logic          i_capture,
    input  inst_addr_t    i_target,
    input  logic          i_clear,
    output logic          o_valid,
    output inst_addr_t    o_target
);

    logic       r_valid;
    inst_addr_t r_target;

    // Capture (or overwrite) the pending target; clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            r_valid  <= 1'b0;
            r_target <= '0;
        end else if (i_clear) begin
            r_valid  <= 1'b0;
        end else if (i_capture) begin
            r_valid  <= 1'b1;
            r_target <= i_target;
        end
    end

    assign o_valid  = r_valid;
    assign o_target = r_target;

endmodule

// File: rtl/if_pc_gen.sv
// Instruction-fetch PC generator: holds the fetch PC, drives the ROM, and
// applies redirects in priority order flush > branch (or pending) > pc+inc.
module if_pc_gen
    import if_pc_gen_pkg::*;
#(
    parameter inst_addr_t RESET_VECTOR = RESET_VECTOR_DEF,
    parameter inst_addr_t PC_INC       = PC_INC_DEF
)
(
    input  logic          clk,
    input  reset_status_t rst,
    if_pc_gen_if.slave    fetch
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    inst_addr_t   r_pc;
    inst_addr_t   w_pc_next;
    inst_addr_t   w_pc_inc;
    logic         r_rom_ce;
    logic         w_hold;
    logic         w_pend_capture;
    logic         w_pend_clear;
    logic         w_pend_valid;
    inst_addr_t   w_pend_target;
    logic         w_unused_stall;

    // Only stall[0] concerns this stage; the other bits belong to later stages.
    assign w_unused_stall = ^fetch.stall[5:1];

    // 32-bit addition wraps naturally from 0xFFFF_FFFC to 0x0000_0000.
    assign w_pc_inc = r_pc + PC_INC;
    assign w_hold   = fetch.stall[0] | ~fetch.rom_rdy;

    pc_redirect_buf u_redirect_buf (
        .clk       (clk),
        .rst       (rst),
        .i_capture (w_pend_capture),
        .i_target  (fetch.branch_target),
        .i_clear   (w_pend_clear),
        .o_valid   (w_pend_valid),
        .o_target  (w_pend_target)
    );

    // Next-state, next-pc and redirect-buffer control.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_pend_capture = 1'b0;
        w_pend_clear   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_FETCH;
                if (fetch.flush) begin
                    w_pc_next    = fetch.flush_pc;
                    w_pend_clear = 1'b1;
                end
            end
            S_FETCH: begin
                if (fetch.flush) begin
                    w_pc_next    = fetch.flush_pc;
                    w_pend_clear = 1'b1;
                end else if (w_hold) begin
                    w_pend_capture = fetch.branch_flag;
                end else begin
                    w_pend_clear = 1'b1;
                    if (fetch.branch_flag) begin
                        w_pc_next = fetch.branch_target;
                    end else if (w_pend_valid) begin
                        w_pc_next = w_pend_target;
                    end else begin
                        w_pc_next = w_pc_inc;
                    end
                end
            end
        endcase
    end

    // State, pc and registered ROM chip enable.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst == RST_ENABLE) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_VECTOR;
            r_rom_ce <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_rom_ce <= (w_state_next == S_FETCH);
        end
    end

    assign fetch.rom_ce      = r_rom_ce;
    assign fetch.pc          = r_pc;
    assign fetch.rom_addr    = r_pc;
    assign fetch.stallreq_if = r_rom_ce & ~fetch.rom_rdy;

endmodule

// File: tb/tb_if_pc_gen.sv
// Scoreboard bench for if_pc_gen: a driver applies directed and random
// cycles, a reference model predicts the visible outputs, a monitor compares.
module tb_if_pc_gen;
    import if_pc_gen_pkg::*;

    localparam inst_addr_t RV  = 32'hBFC0_0000;
    localparam inst_addr_t INC = 32'd4;

    logic          clk = 1'b0;
    reset_status_t rst;
    if_pc_gen_if   bus ();

    if_pc_gen #(.RESET_VECTOR(RV), .PC_INC(INC)) dut (
        .clk   (clk),
        .rst   (rst),
        .fetch (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        inst_addr_t pc;
        logic       ce;
        logic       sreq;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: the fetch address, whether fetching has started, and
    // the most recent branch seen while the PC was not allowed to move.
    inst_addr_t m_pc;
    bit         m_fetching;
    inst_addr_t m_pending[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc       = RV;
        m_fetching = 1'b0;
        m_pending.delete();
    endtask

    task automatic push_expect(logic rdy);
        exp_t e;
        e.pc   = m_pc;
        e.ce   = m_fetching;
        e.sreq = m_fetching && !rdy;
        exp_q.push_back(e);
    endtask

    // Effect of the coming clock edge on the model.
    task automatic model_edge(logic [5:0] st, logic fl, inst_addr_t fpc,
                              logic br, inst_addr_t bt, logic rdy);
        if (fl) begin
            m_pc = fpc;
            m_pending.delete();
        end else if (m_fetching) begin
            if (st[0] || !rdy) begin
                if (br) m_pending = '{bt};
            end else if (br) begin
                m_pc = bt;
                m_pending.delete();
            end else if (m_pending.size() > 0) begin
                m_pc = m_pending.pop_front();
            end else begin
                m_pc = m_pc + INC;
            end
        end
        m_fetching = 1'b1;
    endtask

    // One clock cycle of stimulus, applied just after the rising edge.
    task automatic step(logic r, logic [5:0] st, logic fl, inst_addr_t fpc,
                        logic br, inst_addr_t bt, logic rdy);
        @(posedge clk);
        #1;
        rst               = r;
        bus.stall         = st;
        bus.flush         = fl;
        bus.flush_pc      = fpc;
        bus.branch_flag   = br;
        bus.branch_target = bt;
        bus.rom_rdy       = rdy;
        if (r) begin
            model_reset();
            push_expect(rdy);
        end else begin
            push_expect(rdy);
            model_edge(st, fl, fpc, br, bt, rdy);
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'd0, 1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    // Reset asserted between clock edges must take effect immediately.
    task automatic mid_cycle_reset();
        @(posedge clk);
        #1;
        bus.stall       = 6'd0;
        bus.flush       = 1'b0;
        bus.branch_flag = 1'b0;
        bus.rom_rdy     = 1'b1;
        #2;
        rst = RST_ENABLE;
        #1;
        check("async_rst_pc", bus.pc, RV);
        check("async_rst_rom_ce", 32'(bus.rom_ce), 32'd0);
        model_reset();
        push_expect(1'b1);
    endtask

    // Monitor: the DUT presents pc/rom_ce/stallreq_if every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", bus.pc, e.pc);
                check("rom_addr", bus.rom_addr, e.pc);
                check("rom_ce", 32'(bus.rom_ce), 32'(e.ce));
                check("stallreq_if", 32'(bus.stallreq_if), 32'(e.sreq));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = RST_ENABLE;
        bus.stall         = 6'd0;
        bus.flush         = 1'b0;
        bus.flush_pc      = '0;
        bus.branch_flag   = 1'b0;
        bus.branch_target = '0;
        bus.rom_rdy       = 1'b1;
        model_reset();

        // Reset, release, sequential fetch from the reset vector.
        step(1'b1, 6'd0, 1'b0, '0, 1'b0, '0, 1'b1);
        step(1'b1, 6'd0, 1'b0, '0, 1'b0, '0, 1'b1);
        run(3);

        // ROM wait for three cycles at 0xBFC0_0008.
        for (int i = 0; i < 3; i++) step(1'b0, 6'd0, 1'b0, '0, 1'b0, '0, 1'b0);
        run(2);

        // Branch pulsed under stall, stall released two cycles later.
        step(1'b0, 6'd1, 1'b0, '0, 1'b1, 32'h8000_0100, 1'b1);
        step(1'b0, 6'd1, 1'b0, '0, 1'b0, '0, 1'b1);
        step(1'b0, 6'd1, 1'b0, '0, 1'b0, '0, 1'b1);
        run(3);

        // Flush and branch in the same cycle: flush wins.
        step(1'b0, 6'd0, 1'b1, 32'hBFC0_0380, 1'b1, 32'h8000_0200, 1'b1);
        run(3);

        // Upper stall bits do not freeze the PC.
        step(1'b0, 6'b111110, 1'b0, '0, 1'b0, '0, 1'b1);
        run(1);

        // Wrap-around from the top of the address space.
        step(1'b0, 6'd0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        run(3);

        // Reset while a branch is pending.
        step(1'b0, 6'd1, 1'b0, '0, 1'b1, 32'h8000_0300, 1'b1);
        mid_cycle_reset();
        step(1'b1, 6'd0, 1'b0, '0, 1'b0, '0, 1'b1);
        run(4);

        // Flush during S_IDLE.
        step(1'b1, 6'd0, 1'b0, '0, 1'b0, '0, 1'b1);
        step(1'b0, 6'd0, 1'b1, 32'h0000_1000, 1'b0, '0, 1'b1);
        run(2);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [5:0] st;
            logic       fl, br, rdy, r;
            st  = 6'($urandom);
            st[0] = ($urandom_range(3) == 0);
            fl  = ($urandom_range(19) == 0);
            br  = ($urandom_range(6) == 0);
            rdy = ($urandom_range(3) != 0);
            r   = ($urandom_range(99) == 0);
            step(r, st, fl, $urandom, br, $urandom, rdy);
        end
        run(2);

        @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_pc_gen.md
Name: if_pc_gen

Overview:
- Instruction-fetch PC generator; the stage directly upstream of the IF/ID pipeline register.
- Holds the architectural fetch PC and drives the instruction ROM address and chip-enable.
- Applies the redirect sources in priority order: exception flush, then branch, then sequential.
- Raises a stall request while the ROM has not returned the current word; the pc output feeds the pc field of the IF instruction bundle.

Parameters:
- RESET_VECTOR, 32'hBFC0_0000, PC value loaded on reset.
- PC_INC, 32'd4, sequential increment in bytes.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  reset_status_t (1)  asynchronous, active-high reset; asserted when rst == RST_ENABLE.
- stall  input  6  pipeline stall vector from the controller; stall[0] freezes the PC.
- flush  input  1  exception/ERET redirect request.
- flush_pc  input  32  redirect target for flush.
- branch_flag  input  1  taken branch or jump resolved in ID.
- branch_target  input  32  branch or jump destination.
- rom_rdy  input  1  ROM has returned valid data for rom_addr this cycle.
- rom_ce  output  1  ROM chip enable.
- rom_addr  output  32  ROM byte address; always equal to pc.
- pc  output  32  current fetch PC, sent to the IF/ID register.
- stallreq_if  output  1  request to stall the pipeline because the fetch is outstanding.

Behaviour:
- Reset (asynchronous, effective immediately on rst == RST_ENABLE):
  - pc = RESET_VECTOR, rom_ce = 0, state = S_IDLE.
  - pend_valid = 0, pend_target = 0.
- States:
  - S_IDLE: rom_ce = 0. The first posedge with reset deasserted goes to S_FETCH; pc holds RESET_VECTOR, so the first fetched address is RESET_VECTOR.
  - S_FETCH: rom_ce = 1. Stays here until the next reset.
- rom_ce is registered. pc and rom_addr are the same register.
- stallreq_if = rom_ce & ~rom_rdy. This output is combinational and has no internal dependence on stall.
- Per posedge in S_FETCH, evaluated in this priority order:
  1. flush = 1: pc <= flush_pc; pend_valid <= 0. Applies regardless of stall or rom_rdy.
  2. stall[0] = 1 or rom_rdy = 0 (hold):
     - pc unchanged.
     - If branch_flag = 1: pend_valid <= 1 and pend_target <= branch_target. A newer branch overwrites an older pending one.
  3. Advance (no flush, no hold):
     - If branch_flag = 1: pc <= branch_target; pend_valid <= 0.
     - Else if pend_valid = 1: pc <= pend_target; pend_valid <= 0.
     - Else: pc <= pc + PC_INC, computed modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- Flush and branch in the same cycle: flush wins and the branch is discarded.
- Branch timing: branch_flag is sampled once per cycle. The delay-slot instruction has already been fetched when ID asserts branch_flag, so the next fetch address is the target.
- Flush during S_IDLE: pc <= flush_pc, and the state still goes to S_FETCH.
- Reset in the middle of a fetch or while a branch is pending: all state returns to reset values; no pending redirect survives.
- Address alignment is not checked here. flush_pc and branch_target pass through unmodified, and address-error exceptions are raised downstream.

Decomposition:
- project_types package:
  - RESET_VECTOR default constant.
  - fetch_state_t enum {S_IDLE, S_FETCH}.
  - inst_addr_t typedef (logic [31:0]), used for pc, flush_pc and branch_target.
  - Existing reset_status_t and RST_ENABLE.
- One sub-module, pc_redirect_buf: pend_valid/pend_target storage with capture, overwrite and clear inputs, and the same asynchronous reset.
- The top level keeps the FSM, the priority mux and the adder.

Test Plan:
- Reset then release with rom_rdy = 1: cycle 0 rom_ce = 0, pc = 0xBFC0_0000. Cycle 1 rom_ce = 1, pc = 0xBFC0_0000. Then 0xBFC0_0004, 0xBFC0_0008 on consecutive cycles.
- ROM wait: rom_rdy = 0 for 3 cycles at pc = 0xBFC0_0008. pc holds and stallreq_if = 1 for all 3 cycles; pc = 0xBFC0_000C one cycle after rom_rdy returns to 1.
- Branch under stall: stall[0] = 1 with branch_flag = 1 and target 0x8000_0100 pulsed, then stall released 2 cycles later. pc holds during the stall, then goes straight to 0x8000_0100, not pc + 4.
- Flush versus branch: flush = 1 with flush_pc = 0xBFC0_0380 and branch_flag = 1 with target 0x8000_0200 in the same cycle. pc = 0xBFC0_0380 and no later jump to 0x8000_0200.
- Wrap-around: force pc = 0xFFFF_FFFC with no stall. Next pc = 0x0000_0000.
- Asynchronous reset mid-pending: pending branch 0x8000_0300 captured, rst pulsed between clock edges. pc = 0xBFC0_0000 and rom_ce = 0 immediately; after release the sequence restarts at 0xBFC0_0000 with no jump to 0x8000_0300.
